// File: rtl/bram_arb_pkg.sv
// Shared types for the BRAM port arbiter: requester ownership and read-tracking tags.
package bram_arb_pkg;

  typedef enum logic {OWNER_A = 1'b0, OWNER_B = 1'b1} owner_t;

  typedef struct packed {
    logic   valid;
    owner_t owner;
  } read_tag_t;

  localparam int unsigned MAX_READ_LATENCY = 4;

endpackage

// File: rtl/bram_arb_tag_pipe.sv
// Fixed-depth shift pipe carrying read tags alongside the RAM read latency.
module bram_arb_tag_pipe
  import bram_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 1
) (
  input  logic      clock,
  input  logic      reset,
  input  read_tag_t tag_in,
  output read_tag_t tag_out
);

  read_tag_t [DEPTH-1:0] stage;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stage <= '0;
    end else begin
      stage[0] <= tag_in;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign tag_out = stage[DEPTH-1];

endmodule

// File: rtl/bram_port_arbiter.sv
// Two Avalon-MM requesters sharing one BRAM port; per-cycle grant, tagged read return.
// BRAM_ARB_ROUND_ROBIN_EN selects round-robin contention; otherwise A has fixed priority.
module bram_port_arbiter
  import bram_arb_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH  = 12,
  parameter int unsigned BYTE_WIDTH     = 8,
  parameter int unsigned BYTES_PER_WORD = 4,
  parameter int unsigned READ_LATENCY   = 1
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic [ADDRESS_WIDTH-1:0]             avs_a_address,
  input  logic [BYTES_PER_WORD-1:0]            avs_a_byteenable,
  input  logic                                 avs_a_read,
  input  logic                                 avs_a_write,
  input  logic [BYTES_PER_WORD*BYTE_WIDTH-1:0] avs_a_writedata,
  output logic                                 avs_a_waitrequest,
  output logic [BYTES_PER_WORD*BYTE_WIDTH-1:0] avs_a_readdata,
  output logic                                 avs_a_readdatavalid,
  input  logic [ADDRESS_WIDTH-1:0]             avs_b_address,
  input  logic [BYTES_PER_WORD-1:0]            avs_b_byteenable,
  input  logic                                 avs_b_read,
  input  logic                                 avs_b_write,
  input  logic [BYTES_PER_WORD*BYTE_WIDTH-1:0] avs_b_writedata,
  output logic                                 avs_b_waitrequest,
  output logic [BYTES_PER_WORD*BYTE_WIDTH-1:0] avs_b_readdata,
  output logic                                 avs_b_readdatavalid,
  output logic [ADDRESS_WIDTH-1:0]             avm_address,
  output logic [BYTES_PER_WORD-1:0]            avm_byteenable,
  output logic                                 avm_read,
  output logic                                 avm_write,
  output logic [BYTES_PER_WORD*BYTE_WIDTH-1:0] avm_writedata,
  input  logic [BYTES_PER_WORD*BYTE_WIDTH-1:0] avm_readdata
);

`ifdef BRAM_ARB_ROUND_ROBIN_EN
  localparam bit ROUND_ROBIN = 1'b1;
`else
  localparam bit ROUND_ROBIN = 1'b0;
`endif

  logic      a_active;
  logic      b_active;
  logic      prefer_a;
  logic      grant_a;
  logic      grant_b;
  owner_t    last_grant;
  read_tag_t tag_in;
  read_tag_t tag_out;

  // Reset blocks all grants so both requesters stall and the RAM sees no access.
  always_comb begin
    a_active = avs_a_read | avs_a_write;
    b_active = avs_b_read | avs_b_write;
    prefer_a = !ROUND_ROBIN || (last_grant == OWNER_B);
    grant_a  = !reset && a_active && (!b_active || prefer_a);
    grant_b  = !reset && b_active && !grant_a;
  end

  always_comb begin
    avm_address    = grant_b ? avs_b_address    : avs_a_address;
    avm_byteenable = grant_b ? avs_b_byteenable : avs_a_byteenable;
    avm_writedata  = grant_b ? avs_b_writedata  : avs_a_writedata;
    avm_read       = (grant_a & avs_a_read)  | (grant_b & avs_b_read);
    avm_write      = (grant_a & avs_a_write) | (grant_b & avs_b_write);
  end

  assign avs_a_waitrequest = reset | (a_active & !grant_a);
  assign avs_b_waitrequest = reset | (b_active & !grant_b);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_grant <= OWNER_B;
    end else if (grant_a) begin
      last_grant <= OWNER_A;
    end else if (grant_b) begin
      last_grant <= OWNER_B;
    end
  end

  always_comb begin
    tag_in       = '0;
    tag_in.valid = avm_read;
    tag_in.owner = grant_b ? OWNER_B : OWNER_A;
  end

  bram_arb_tag_pipe #(
    .DEPTH(READ_LATENCY)
  ) u_tag_pipe (
    .clock  (clock),
    .reset  (reset),
    .tag_in (tag_in),
    .tag_out(tag_out)
  );

  assign avs_a_readdatavalid = tag_out.valid && (tag_out.owner == OWNER_A);
  assign avs_b_readdatavalid = tag_out.valid && (tag_out.owner == OWNER_B);
  assign avs_a_readdata      = avm_readdata;
  assign avs_b_readdata      = avm_readdata;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Self-checking bench for bram_port_arbiter with a behavioural BRAM and read scoreboard.
module tb_bram_port_arbiter;
  import bram_arb_pkg::*;

  localparam int unsigned AW = 12;
  localparam int unsigned DW = 32;
  localparam int unsigned RL = 3;
`ifdef BRAM_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct packed {
    logic          rd;
    logic          wr;
    logic [AW-1:0] addr;
    logic [3:0]    be;
    logic [DW-1:0] wd;
  } cmd_t;

  typedef struct {
    owner_t        owner;
    logic [DW-1:0] data;
    int unsigned   due;
  } exp_t;

  logic          clock;
  logic          reset;
  logic [AW-1:0] avs_a_address, avs_b_address, avm_address;
  logic [3:0]    avs_a_byteenable, avs_b_byteenable, avm_byteenable;
  logic          avs_a_read, avs_a_write, avs_b_read, avs_b_write;
  logic [DW-1:0] avs_a_writedata, avs_b_writedata, avm_writedata;
  logic          avs_a_waitrequest, avs_b_waitrequest;
  logic [DW-1:0] avs_a_readdata, avs_b_readdata, avm_readdata;
  logic          avs_a_readdatavalid, avs_b_readdatavalid;
  logic          avm_read, avm_write;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  int unsigned cyc = 0;
  exp_t        sb[$];
  owner_t      m_last;
  logic [DW-1:0] ref_mem [0:4095];

  bram_port_arbiter #(
    .ADDRESS_WIDTH (AW),
    .BYTE_WIDTH    (8),
    .BYTES_PER_WORD(4),
    .READ_LATENCY  (RL)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .avs_a_address      (avs_a_address),
    .avs_a_byteenable   (avs_a_byteenable),
    .avs_a_read         (avs_a_read),
    .avs_a_write        (avs_a_write),
    .avs_a_writedata    (avs_a_writedata),
    .avs_a_waitrequest  (avs_a_waitrequest),
    .avs_a_readdata     (avs_a_readdata),
    .avs_a_readdatavalid(avs_a_readdatavalid),
    .avs_b_address      (avs_b_address),
    .avs_b_byteenable   (avs_b_byteenable),
    .avs_b_read         (avs_b_read),
    .avs_b_write        (avs_b_write),
    .avs_b_writedata    (avs_b_writedata),
    .avs_b_waitrequest  (avs_b_waitrequest),
    .avs_b_readdata     (avs_b_readdata),
    .avs_b_readdatavalid(avs_b_readdatavalid),
    .avm_address        (avm_address),
    .avm_byteenable     (avm_byteenable),
    .avm_read           (avm_read),
    .avm_write          (avm_write),
    .avm_writedata      (avm_writedata),
    .avm_readdata       (avm_readdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [DW-1:0] init_word(input int unsigned a);
    logic [AW-1:0] w;
    w = AW'(a);
    case (a)
      32'h010: return 32'hDEADBEEF;
      32'h020: return 32'h11223344;
      default: return {4'h5, w, 4'hC, w};
    endcase
  endfunction

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] wd,
                                          input logic [3:0] be);
    logic [DW-1:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
    return r;
  endfunction

  // Behavioural BRAM: registered read of pre-write data, then RL-1 further delay stages.
  logic [DW-1:0] mem [0:4095];
  logic [DW-1:0] rd_pipe [0:RL-1];
  logic          loaded = 1'b0;
  always @(posedge clock) begin
    if (!loaded) begin
      for (int i = 0; i < 4096; i++) mem[i] <= init_word(i);
      loaded <= 1'b1;
    end else if (avm_write) begin
      mem[avm_address] <= merge(mem[avm_address], avm_writedata, avm_byteenable);
    end
    rd_pipe[0] <= mem[avm_address];
    for (int i = 1; i < int'(RL); i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign avm_readdata = rd_pipe[RL-1];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Response checker: every cycle, the scoreboard head decides which valid is due.
  always @(negedge clock) begin
    logic ea, eb;
    ea = 1'b0;
    eb = 1'b0;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      ea = (sb[0].owner == OWNER_A);
      eb = !ea;
    end
    check_eq("rdv_a", 32'(avs_a_readdatavalid), 32'(ea));
    check_eq("rdv_b", 32'(avs_b_readdatavalid), 32'(eb));
    if (ea) check_eq("rdata_a", avs_a_readdata, sb[0].data);
    if (eb) check_eq("rdata_b", avs_b_readdata, sb[0].data);
    if (ea || eb) void'(sb.pop_front());
  end

  function automatic cmd_t rd_cmd(input int unsigned a);
    cmd_t c = '0;
    c.rd = 1'b1; c.addr = AW'(a);
    return c;
  endfunction

  function automatic cmd_t wr_cmd(input int unsigned a, input logic [3:0] be, input logic [DW-1:0] wd);
    cmd_t c = '0;
    c.wr = 1'b1; c.addr = AW'(a); c.be = be; c.wd = wd;
    return c;
  endfunction

  task automatic drive(input cmd_t ca, input cmd_t cb);
    avs_a_read = ca.rd; avs_a_write = ca.wr; avs_a_address = ca.addr;
    avs_a_byteenable = ca.be; avs_a_writedata = ca.wd;
    avs_b_read = cb.rd; avs_b_write = cb.wr; avs_b_address = cb.addr;
    avs_b_byteenable = cb.be; avs_b_writedata = cb.wd;
  endtask

  // One bus cycle, entered 1ns after a rising edge; leaves 1ns after the next one.
  task automatic step(input cmd_t ca, input cmd_t cb, output bit acc_a, output bit acc_b);
    logic act_a, act_b, win_a, win_b;
    cmd_t w;
    drive(ca, cb);
    #2;
    act_a = ca.rd | ca.wr;
    act_b = cb.rd | cb.wr;
    win_a = act_a && (!act_b || !RR || m_last == OWNER_B);
    win_b = act_b && !win_a;
    check_eq("wait_a", 32'(avs_a_waitrequest), 32'(act_a && !win_a));
    check_eq("wait_b", 32'(avs_b_waitrequest), 32'(act_b && !win_b));
    check_eq("avm_read", 32'(avm_read), 32'((win_a && ca.rd) || (win_b && cb.rd)));
    check_eq("avm_write", 32'(avm_write), 32'((win_a && ca.wr) || (win_b && cb.wr)));
    if (win_a || win_b) begin
      w = win_a ? ca : cb;
      check_eq("avm_address", 32'(avm_address), 32'(w.addr));
      if (w.wr) begin
        check_eq("avm_byteenable", 32'(avm_byteenable), 32'(w.be));
        check_eq("avm_writedata", avm_writedata, w.wd);
      end
      if (w.rd) sb.push_back('{win_a ? OWNER_A : OWNER_B, ref_mem[w.addr], cyc + RL});
      if (w.wr) ref_mem[w.addr] = merge(ref_mem[w.addr], w.wd, w.be);
      m_last = win_a ? OWNER_A : OWNER_B;
    end
    acc_a = win_a;
    acc_b = win_b;
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int unsigned n);
    bit aa, ab;
    repeat (n) step('0, '0, aa, ab);
  endtask

  task automatic hold_pair(input cmd_t ca, input cmd_t cb);
    bit da, db, aa, ab;
    da = !(ca.rd | ca.wr);
    db = !(cb.rd | cb.wr);
    for (int k = 0; k < 8 && !(da && db); k++) begin
      step(da ? cmd_t'('0) : ca, db ? cmd_t'('0) : cb, aa, ab);
      da |= aa;
      db |= ab;
    end
    check_eq("hold_done", 32'({da, db}), 32'b11);
  endtask

  task automatic reset_checks(input string tag);
    check_eq({tag, "_wait_a"}, 32'(avs_a_waitrequest), 32'd1);
    check_eq({tag, "_wait_b"}, 32'(avs_b_waitrequest), 32'd1);
    check_eq({tag, "_avm_rw"}, 32'({avm_read, avm_write}), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete, got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit aa, ab;
    int unsigned na, nb;
    for (int i = 0; i < 4096; i++) ref_mem[i] = init_word(i);
    reset = 1'b1;
    m_last = OWNER_B;
    drive(rd_cmd(32'h5), rd_cmd(32'h6));
    #2;
    reset_checks("por");
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;

    // Lone A read, then a lone B read leaving last_grant at B.
    step(rd_cmd(32'h010), '0, aa, ab);
    step('0, rd_cmd(32'h011), aa, ab);
    idle(RL + 1);

    // Both write continuously; each holds a write until accepted.
    na = 0;
    nb = 0;
    for (int k = 0; k < 16 && (na < 4 || nb < 4); k++) begin
      step(na < 4 ? wr_cmd(32'h100 + na, 4'hF, 32'hA000_0000 + na) : cmd_t'('0),
           nb < 4 ? wr_cmd(32'h200 + nb, 4'hF, 32'hB000_0000 + nb) : cmd_t'('0), aa, ab);
      if (aa) na++;
      if (ab) nb++;
    end
    check_eq("wr_drain", na + nb, 32'd8);
    hold_pair(rd_cmd(32'h103), rd_cmd(32'h203));
    idle(RL + 1);

    // Interleaved A/B/A reads, then back-to-back A reads.
    step(rd_cmd(32'h1), '0, aa, ab);
    step('0, rd_cmd(32'h2), aa, ab);
    step(rd_cmd(32'h3), '0, aa, ab);
    for (int i = 0; i < 4; i++) step(rd_cmd(32'h40 + i), '0, aa, ab);
    idle(RL + 1);

    // Partial-lane write, then combined read+write returning the pre-write word.
    step(wr_cmd(32'h020, 4'b0010, 32'h0000AB00), '0, aa, ab);
    step(rd_cmd(32'h020), '0, aa, ab);
    step(wr_cmd(32'h030, 4'hF, 32'hCAFEF00D) | cmd_t'({1'b1, {($bits(cmd_t)-1){1'b0}}}), '0, aa, ab);
    step(rd_cmd(32'h030), '0, aa, ab);
    idle(RL + 1);

    // Reset one cycle after an accepted read: that response must never appear.
    step(rd_cmd(32'h010), '0, aa, ab);
    reset = 1'b1;
    drive(rd_cmd(32'h7), rd_cmd(32'h8));
    sb.delete();
    m_last = OWNER_B;
    #2;
    reset_checks("mid");
    @(posedge clock);
    #1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    idle(RL + 1);
    hold_pair(rd_cmd(32'h011), rd_cmd(32'h012));
    idle(RL + 2);

    check_eq("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bram_port_arbiter.md
# bram_port_arbiter

Shares one port of the dual-port block RAM between two Avalon-MM requesters, such as core data accesses and a debug/loader master. Each requester sees an Avalon-MM slave with waitrequest and readdatavalid. The RAM port is driven as an Avalon-MM master with fixed read latency. The block arbitrates per cycle, forwards the winning command, and routes returned read data to the requester that issued it.

## Interface
- ADDRESS_WIDTH, 12, word address width; matches the RAM.
- BYTE_WIDTH, 8, bits per byte lane.
- BYTES_PER_WORD, 4, byte lanes per word.
- READ_LATENCY, 1, cycles from an accepted read to valid avm_readdata; legal range 1..4.

Ports (x ∈ {a, b}):
- clock  in  1  single clock domain; all logic on rising edge.
- reset  in  1  asynchronous, active-high.
- avs_x_address  in  ADDRESS_WIDTH  requester word address.
- avs_x_byteenable  in  BYTES_PER_WORD  write lane enables.
- avs_x_read  in  1  read request; held until accepted.
- avs_x_write  in  1  write request; held until accepted.
- avs_x_writedata  in  BYTES_PER_WORD×BYTE_WIDTH  write data.
- avs_x_waitrequest  out  1  high = request not accepted this cycle.
- avs_x_readdata  out  BYTES_PER_WORD×BYTE_WIDTH  read data; valid only with readdatavalid.
- avs_x_readdatavalid  out  1  one-cycle pulse per accepted read.
- avm_address  out  ADDRESS_WIDTH  to the RAM port.
- avm_byteenable  out  BYTES_PER_WORD  to the RAM port.
- avm_read  out  1  to the RAM port.
- avm_write  out  1  to the RAM port.
- avm_writedata  out  BYTES_PER_WORD×BYTE_WIDTH  to the RAM port.
- avm_readdata  in  BYTES_PER_WORD×BYTE_WIDTH  from the RAM port, READ_LATENCY after avm_read.

## Operation
- Requester x is active when avs_x_read or avs_x_write is high.
- Each cycle, at most one active requester is granted, combinationally.
  - The granted requester sees waitrequest=0.
  - Its address, byteenable, read, write and writedata drive avm_* in the same cycle.
- A non-granted active requester sees waitrequest=1 and must hold its command stable.
- An idle requester sees waitrequest=0; don't-care by protocol.
- No grant: avm_read=0 and avm_write=0. avm_address, byteenable and writedata are don't-care; drive them from requester A.
- Read and write asserted together by one requester: both are forwarded in one access. The RAM returns the pre-write data, and one readdatavalid is issued.
- Read tracking:
  - An accepted read pushes tag {valid=1, owner=x} into a READ_LATENCY-deep shift pipe.
  - The tag exiting the pipe drives avs_owner_readdatavalid=1.
  - Both avs_x_readdata outputs are driven directly from avm_readdata.
  - The pipe advances every cycle, so any mix of A/B reads can be in flight and responses stay in issue order.
- Arbitration state: a register last_grant ∈ {A, B}, updated on every cycle in which a grant occurs.

## Timing
- Grant, waitrequest and avm_* are combinational from the requests and last_grant; zero added command latency.
- Read response: readdatavalid asserts exactly READ_LATENCY cycles after the acceptance edge.
- Throughput: one access per cycle. Back-to-back reads from one requester yield consecutive readdatavalid pulses.
- While reset is high:
  - last_grant = B, so A wins the first contention.
  - Tag pipe cleared.
  - Both readdatavalid = 0.
  - Both waitrequest = 1.
  - avm_read = avm_write = 0.
- Reset asserted mid-operation: in-flight reads are discarded and no readdatavalid is produced for them. Requesters re-issue after reset.
- Deassertion: the first accept can occur in the first cycle with reset low.

## Configuration
- BRAM_ARB_ROUND_ROBIN_EN defined: round-robin. On contention, the requester other than last_grant wins, so contending requesters alternate A, B, A, B.
- Undefined: fixed priority. A always wins contention and B is granted only when A is idle. last_grant is still maintained but does not affect the grant.

## Structure
- Package bram_arb_pkg holds:
  - typedef enum logic {OWNER_A, OWNER_B} owner_t;
  - typedef struct packed {logic valid; owner_t owner;} read_tag_t;
  - localparam MAX_READ_LATENCY = 4.
- Sub-module bram_arb_tag_pipe: a READ_LATENCY-stage read_tag_t shift register with async reset, input tag and output tag.
- Top level: grant logic, command mux, response demux.

## Test plan
- Single A read of address 0x010 (RAM word 0xDEADBEEF), B idle, READ_LATENCY=1 -> avs_a_waitrequest=0; avs_a_readdatavalid one cycle later with 0xDEADBEEF; avs_b_readdatavalid stays 0.
- A and B both write continuously for 4 cycles with round-robin enabled -> accepts A, B, A, B; each waitrequest toggles; RAM holds both requesters' final values.
- Same contention with the macro undefined -> A accepted all 4 cycles; B waitrequest=1 throughout; B accepted in the cycle A drops.
- READ_LATENCY=3, interleaved reads A@0x1, B@0x2, A@0x3 -> readdatavalid pulses A, B, A on cycles 3, 4, 5 after the first accept, with the matching data.
- A write with byteenable=4'b0010 and data 0x0000AB00 to a word holding 0x11223344, then an A read -> returns 0x1122AB44.
- Reset pulsed one cycle after an accepted read at READ_LATENCY=2 -> no readdatavalid ever appears for that read; both waitrequest=1 during reset.
